regfile_dump_reader: RTL and testbench

- Read side of the processor's register storage: NUM_REGS x DATA_W register file with one write port and two combinational read ports (rs/rt) for the single-cycle datapath.
- Adds a sequential dump engine. On request it streams every register out over a valid/ready interface to the debug/trace path.
- Sits between writeback (write port), decode/ALU operand fetch (read ports) and the debug unit (dump stream).

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_read_port.sv | 17 +
 rtl/regfile_dump_reader.sv | 84 ++++++++
 tb/tb_regfile_dump_reader.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, dump FSM state encoding and register-0 index
package regfile_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int REG_ZERO = 0;
  typedef enum logic [1:0] {IDLE = 2'd0, DUMP = 2'd1, DONE = 2'd2} dump_state_t;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: zero-reg masking + write-through bypass; raddr/rval(stored regs[raddr])/we/waddr/wdata in, rdata out
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] rval,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  always_comb rdata = (ZERO_REG && raddr == ADDR_W'(REG_ZERO)) ? '0 : (we && waddr == raddr) ? wdata : rval;
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: regfile with 1 write port (we/waddr/wdata), 2 comb read ports (raddr_a/b->rdata_a/b) and a valid/ready dump stream (dump_start, dump_valid/ready/addr/data, dump_busy, dump_done)
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  dump_state_t state, state_n;
  logic [ADDR_W-1:0] addr_n, fetch_addr;
  logic [DATA_W-1:0] data_n, fetch_data;
  logic valid_n;
  always_ff @(posedge clk)
    if (reset) regs <= '{default: '0};
    else if (we && !(ZERO_REG && waddr == ADDR_W'(REG_ZERO))) regs[waddr] <= wdata;
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port_a (
    .raddr(raddr_a), .rval(regs[raddr_a]), .we(we), .waddr(waddr), .wdata(wdata), .rdata(rdata_a)
  );
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port_b (
    .raddr(raddr_b), .rval(regs[raddr_b]), .we(we), .waddr(waddr), .wdata(wdata), .rdata(rdata_b)
  );
  always_comb fetch_addr = (state == IDLE) ? ADDR_W'(REG_ZERO) : dump_addr + 1'b1;
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_port_dump (
    .raddr(fetch_addr), .rval(regs[fetch_addr]), .we(we), .waddr(waddr), .wdata(wdata), .rdata(fetch_data)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      dump_addr <= '0;
      dump_data <= '0;
      dump_valid <= 1'b0;
    end else begin
      state <= state_n;
      dump_addr <= addr_n;
      dump_data <= data_n;
      dump_valid <= valid_n;
    end
  always_comb begin
    state_n = state;
    addr_n = dump_addr;
    data_n = dump_data;
    valid_n = dump_valid;
    unique case (state)
      IDLE: if (dump_start) begin
        state_n = DUMP;
        addr_n = '0;
        data_n = fetch_data;
        valid_n = 1'b1;
      end
      DUMP: if (dump_valid && dump_ready) begin
        if (dump_addr == ADDR_W'(NUM_REGS - 1)) begin
          state_n = DONE;
          valid_n = 1'b0;
        end else begin
          addr_n = fetch_addr;
          data_n = fetch_data;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb dump_busy = state != IDLE;
  always_comb dump_done = state == DONE;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: model-checked directed bench for regfile_dump_reader
module tb_regfile_dump_reader;
  logic clk = 1'b0, reset = 1'b0, we = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [2:0] waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata_a, rdata_b, dump_data;
  logic [2:0] dump_addr;
  logic dump_valid, dump_busy, dump_done;
  int pass_cnt = 0, total_cnt = 0;
  int beats = 0, dones = 0, busys = 0;
  int b0, d0, y0;
  logic [7:0] m [8];
  logic [7:0] beat_log [8];
  logic armed = 1'b0;
  logic mv = 1'b0, mbusy = 1'b0, mdone = 1'b0;
  logic [2:0] ma = '0;
  logic [7:0] md = '0;

  regfile_dump_reader dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a), .raddr_b(raddr_b), .rdata_b(rdata_b),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [7:0] mread(input logic [2:0] i);
    if (i == 3'd0) return 8'h00;
    if (we && waddr == i) return wdata;
    return m[i];
  endfunction

  // At each falling edge: compare DUT against the model, then advance the
  // model with the inputs that the coming rising edge will see.
  task automatic monitor();
    if (armed) begin
      chk("rdata_a", rdata_a, mread(raddr_a));
      chk("rdata_b", rdata_b, mread(raddr_b));
      chk("dump_valid", dump_valid, mv);
      chk("dump_busy", dump_busy, mbusy);
      chk("dump_done", dump_done, mdone);
      if (mv) begin
        chk("dump_addr", dump_addr, ma);
        chk("dump_data", dump_data, md);
      end
    end
    if (dump_valid && dump_ready) begin
      beats++;
      beat_log[dump_addr] = dump_data;
    end
    if (dump_done) dones++;
    if (dump_busy) busys++;
    if (reset) begin
      armed = 1'b1;
      mv = 1'b0; mbusy = 1'b0; mdone = 1'b0; ma = '0; md = '0;
      for (int i = 0; i < 8; i++) m[i] = 8'h00;
    end else begin
      if (mdone) begin
        mdone = 1'b0;
        mbusy = 1'b0;
      end else if (!mbusy) begin
        if (dump_start) begin
          mbusy = 1'b1; mv = 1'b1; ma = 3'd0; md = mread(3'd0);
        end
      end else if (mv && dump_ready) begin
        if (ma == 3'd7) begin
          mv = 1'b0;
          mdone = 1'b1;
        end else begin
          ma = ma + 3'd1;
          md = mread(ma);
        end
      end
      if (we && waddr != 3'd0) m[waddr] = wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) beat_log[i] = 8'h00;
    reset = 1'b1; we = 1'b1; waddr = 3'd3; wdata = 8'h5A; raddr_a = 3'd3;
    tick();
    reset = 1'b0; we = 1'b0;
    #1;
    chk("reset_r3", rdata_a, 8'h00);
    chk("reset_rdb", rdata_b, 8'h00);
    chk("reset_valid", dump_valid, 1'b0);
    chk("reset_busy", dump_busy, 1'b0);
    chk("reset_done", dump_done, 1'b0);
    chk("reset_addr", dump_addr, 3'd0);
    chk("reset_data", dump_data, 8'h00);
    tick();
    we = 1'b1; waddr = 3'd5; wdata = 8'hC3; raddr_a = 3'd5; raddr_b = 3'd3;
    #1 chk("bypass_a", rdata_a, 8'hC3);
    tick();
    we = 1'b0;
    #1 chk("after_write_a", rdata_a, 8'hC3);
    tick();
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0; raddr_b = 3'd0;
    #1 chk("zero_bypass_a", rdata_a, 8'h00);
    chk("zero_bypass_b", rdata_b, 8'h00);
    tick();
    we = 1'b0;
    #1 chk("zero_a", rdata_a, 8'h00);
    chk("zero_b", rdata_b, 8'h00);
    for (int i = 1; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = 8'(i * 17); raddr_a = 3'(i); raddr_b = 3'(8 - i);
      tick();
    end
    we = 1'b0;
    tick();
    b0 = beats; d0 = dones; y0 = busys;
    dump_start = 1'b1; dump_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    repeat (10) tick();
    chk("dump1_beats", beats - b0, 8);
    chk("dump1_dones", dones - d0, 1);
    chk("dump1_busy_cycles", busys - y0, 9);
    chk("dump1_beat0", beat_log[0], 8'h00);
    chk("dump1_beat7", beat_log[7], 8'h77);
    dump_start = 1'b1; dump_ready = 1'b1;
    tick();
    dump_start = 1'b0;
    tick();
    tick();
    dump_ready = 1'b0; we = 1'b1; waddr = 3'd2; wdata = 8'hEE;
    tick();
    we = 1'b0;
    tick();
    tick();
    chk("stall_addr", dump_addr, 3'd2);
    chk("stall_data", dump_data, 8'h22);
    dump_ready = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'hAB;
    tick();
    we = 1'b0;
    tick();
    chk("beat4_addr", dump_addr, 3'd4);
    chk("beat4_data", dump_data, 8'hAB);
    chk("beat2_logged", beat_log[2], 8'h22);
    tick();
    dump_start = 1'b1; dump_ready = 1'b0;
    tick();
    chk("start_ignored_addr", dump_addr, 3'd5);
    chk("start_ignored_valid", dump_valid, 1'b1);
    d0 = dones;
    dump_start = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; raddr_a = 3'd4;
    #1 chk("abort_valid", dump_valid, 1'b0);
    chk("abort_busy", dump_busy, 1'b0);
    chk("abort_r4_cleared", rdata_a, 8'h00);
    repeat (3) tick();
    chk("abort_no_done", dones - d0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
